// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-loaded register's write port among NREQ requesters.
// Each grant produces one load cycle (WRITE) followed by a one-cycle ack (DONE).
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      gnt,
  output logic                 reg_en,
  output logic [DW-1:0]        reg_din,
  output logic                 busy,
  output logic [2:0]           last_id
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, win, pick;
  logic [IW1-1:0]  idx;
  logic            found;
  logic [NREQ-1:0] gnt_q, pick_onehot;
  logic [DW-1:0]   data_q, pick_data;

  // First requester at or after ptr; idx is ptr+i folded back into 0..NREQ-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + IW1'(i);
      if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_data      = req_data[i*DW +: DW];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      win     <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      last_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win    <= pick;
            gnt_q  <= pick_onehot;
            data_q <= pick_data;
          end
        end
        DONE: begin
          ptr     <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
          last_id <= 3'(win);
          gnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so an async reset drops them immediately.
  assign gnt     = gnt_q;
  assign reg_en  = (state == WRITE);
  assign reg_din = data_q;
  assign ack     = (state == DONE) ? gnt_q : '0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter with a rotation-order reference model.
module tb_reg_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 7;

  logic                clk, rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     ack, gnt;
  logic                reg_en, busy;
  logic [DW-1:0]       reg_din;
  logic [2:0]          last_id;

  logic [DW-1:0] dat [NREQ];
  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;
  int m_last = 0;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .gnt(gnt), .reg_en(reg_en), .reg_din(reg_din),
    .busy(busy), .last_id(last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat[i];
  end

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  // Serves every pending request from an IDLE negedge; optional random extra requests and data scrambling.
  task automatic drain(input int extra, input bit scramble);
    int w;
    logic [DW-1:0] exp_d;
    int budget;
    logic [NREQ-1:0] add;
    budget = extra;
    while (req != '0) begin
      w = model_pick(req, m_ptr);
      exp_d = dat[w];
      @(negedge clk);
      checks++; if (reg_en !== 1'b1) begin errors++; $display("FAIL drain_en: got %b want 1", reg_en); end
      checks++; if (gnt !== NREQ'(1 << w)) begin errors++; $display("FAIL drain_gnt: got %b want %b", gnt, NREQ'(1 << w)); end
      checks++; if (reg_din !== exp_d) begin errors++; $display("FAIL drain_din: got %h want %h", reg_din, exp_d); end
      checks++; if (ack !== '0 || busy !== 1'b1) begin errors++; $display("FAIL drain_write_ack_busy: got ack=%b busy=%b want ack=0 busy=1", ack, busy); end
      if (scramble && $urandom_range(0, 1) == 1) dat[w] = DW'($urandom);
      @(negedge clk);
      checks++; if (ack !== NREQ'(1 << w)) begin errors++; $display("FAIL drain_ack: got %b want %b", ack, NREQ'(1 << w)); end
      checks++; if (reg_en !== 1'b0 || reg_din !== exp_d) begin errors++; $display("FAIL drain_done: got en=%b din=%h want en=0 din=%h", reg_en, reg_din, exp_d); end
      req[w] = 1'b0;
      if (budget > 0) begin
        add = NREQ'($urandom);
        req = req | add;
        budget--;
      end
      @(negedge clk);
      m_last = w;
      m_ptr  = (w + 1) % NREQ;
      checks++; if (busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL drain_idle: got busy=%b gnt=%b want 0 0", busy, gnt); end
      checks++; if (last_id !== 3'(m_last)) begin errors++; $display("FAIL drain_last_id: got %0d want %0d", last_id, m_last); end
    end
  endtask

  task automatic test_reset;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) dat[i] = DW'(i + 1);
    repeat (3) begin
      @(negedge clk);
      checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
      checks++; if (reg_en !== 1'b0 || ack !== '0) begin errors++; $display("FAIL reset_en_ack: got en=%b ack=%b want 0", reg_en, ack); end
      checks++; if (busy !== 1'b0 || reg_din !== '0 || last_id !== 3'd0) begin errors++; $display("FAIL reset_misc: got busy=%b din=%h last=%0d want 0", busy, reg_din, last_id); end
    end
    req = '0;
    rst = 1'b0;
    m_ptr = 0; m_last = 0;
    @(negedge clk);
  endtask

  task automatic test_rotation;
    dat[0] = 7'h11; dat[1] = 7'h22; dat[2] = 7'h33; dat[3] = 7'h44;
    req = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      @(negedge clk);
      checks++; if (reg_din !== DW'(8'h11 * (n + 1)) || gnt !== NREQ'(1 << n)) begin errors++; $display("FAIL rotation_write: got din=%h gnt=%b want din=%h gnt=%b", reg_din, gnt, DW'(8'h11 * (n + 1)), NREQ'(1 << n)); end
      @(negedge clk);
      checks++; if (ack !== NREQ'(1 << n)) begin errors++; $display("FAIL rotation_ack: got %b want %b", ack, NREQ'(1 << n)); end
      req[n] = 1'b0;
      @(negedge clk);
    end
    m_ptr = 0; m_last = 3;
    checks++; if (last_id !== 3'd3) begin errors++; $display("FAIL rotation_last: got %0d want 3", last_id); end
  endtask

  task automatic test_single;
    dat[2] = 7'h55;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (reg_en !== 1'b1 || reg_din !== 7'h55 || gnt !== 4'b0100) begin errors++; $display("FAIL single_write: got en=%b din=%h gnt=%b want 1 55 0100", reg_en, reg_din, gnt); end
    @(negedge clk);
    checks++; if (ack !== 4'b0100 || reg_en !== 1'b0) begin errors++; $display("FAIL single_ack: got ack=%b en=%b want 0100 0", ack, reg_en); end
    req = '0;
    @(negedge clk);
    checks++; if (last_id !== 3'd2 || busy !== 1'b0) begin errors++; $display("FAIL single_last: got last=%0d busy=%b want 2 0", last_id, busy); end
    m_ptr = 3; m_last = 2;
  endtask

  task automatic test_wrap;
    dat[3] = 7'h6C; dat[0] = 7'h13;
    req = 4'b1001;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000 || reg_din !== 7'h6C) begin errors++; $display("FAIL wrap_first: got gnt=%b din=%h want 1000 6c", gnt, reg_din); end
    @(negedge clk);
    req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || reg_din !== 7'h13) begin errors++; $display("FAIL wrap_second: got gnt=%b din=%h want 0001 13", gnt, reg_din); end
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    m_ptr = 1; m_last = 0;
    // ptr must now be 1: with 0 and 1 both requesting, 1 wins
    req = 4'b0011;
    drain(0, 1'b0);
  endtask

  task automatic test_data_change;
    dat[1] = 7'h0A;
    req = 4'b0010;
    @(negedge clk);
    checks++; if (reg_din !== 7'h0A || reg_en !== 1'b1) begin errors++; $display("FAIL chg_write: got din=%h en=%b want 0a 1", reg_din, reg_en); end
    dat[1] = 7'h7F;
    @(negedge clk);
    checks++; if (ack !== 4'b0010 || reg_din !== 7'h0A) begin errors++; $display("FAIL chg_done: got ack=%b din=%h want 0010 0a", ack, reg_din); end
    req = '0;
    @(negedge clk);
    m_last = 1; m_ptr = 2;
  endtask

  task automatic test_reset_write;
    dat[1] = 7'h2A;
    req = 4'b0010;
    @(negedge clk);
    checks++; if (reg_en !== 1'b1) begin errors++; $display("FAIL rstw_pre: got en=%b want 1", reg_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (reg_en !== 1'b0 || ack !== '0 || busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL rstw_async: got en=%b ack=%b busy=%b gnt=%b want all 0", reg_en, ack, busy, gnt); end
    @(negedge clk);
    checks++; if (ack !== '0 || last_id !== 3'd0) begin errors++; $display("FAIL rstw_noack: got ack=%b last=%0d want 0 0", ack, last_id); end
    rst = 1'b0;
    m_ptr = 0; m_last = 0;
    drain(0, 1'b0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREQ; i++) dat[i] = DW'($urandom);
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drain($urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    #1 rst = 1'b1;
    test_reset;
    test_rotation;
    test_single;
    test_wrap;
    test_data_change;
    test_reset_write;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
